ultrasonic_scan_ctrl: RTL and testbench
=======================================

// Module: ultrasonic_scan_ctrl
// PURPOSE
//   Sequencer for CH HC-SR04-style ultrasonic rangers, replacing the single-channel trigger block.
//   Each channel in turn gets a trigger pulse, a timed echo pulse and a hold-off period.
//   Scans run once per start pulse or continuously.
//   Each measurement is reported as an echo width in clk cycles, with channel index and timeout flag.
//   Sits between the sensor pins and the distance-conversion/display logic.
// PARAMETERS
//   CH           4          number of sensor channels (>=1)
//   CHW          2          channel index width, >= clog2(CH), min 1
//   CW           23         cycle-counter and meas_width width
//   TRIG_CYC     1000       trigger high time in clk cycles (10 us @ 100 MHz)
//   ECHO_MAX_CYC 3800000    echo wait/width limit in cycles (38 ms @ 100 MHz)
//   HOLDOFF_CYC  6000000    gap after each measurement before next trigger (60 ms)
//   Every *_CYC value is >=1 and < 2**CW.
// PORTS
//   clk          in   1      system clock
//   rst          in   1      synchronous, active-high reset
//   start        in   1      one-cycle request for one scan of all channels; sampled only in IDLE
//   continuous   in   1      level: 1 = rescan ch 0 after the last channel; sampled at end of scan
//   echo         in   CH     raw asynchronous echo lines, one per channel
//   trigger      out  CH     trigger lines; at most one bit high at any time
//   busy         out  1      high whenever FSM != IDLE
//   meas_valid   out  1      one-cycle pulse: meas_* fields updated this cycle
//   meas_ch      out  CHW    channel of the latest result
//   meas_width   out  CW     echo high time in cycles; = ECHO_MAX_CYC on timeout
//   meas_timeout out  1      1 = no rising edge, or echo still high, within ECHO_MAX_CYC
// BEHAVIOUR
//   Reset (sync, any state)
//     FSM=IDLE, ch=0, all counters 0, synchronisers 0.
//     trigger=0, busy=0, meas_valid=0, meas_ch=0, meas_width=0, meas_timeout=0.
//   Echo input
//     Each echo bit passes through a 2-flop synchroniser: echo_s lags echo by 2 cycles.
//     An edge detector on echo_s[ch] compares it with its previous value.
//   States
//     IDLE: start=1 or continuous=1 -> TRIG, ch=0, cnt=0.
//     TRIG: trigger[ch]=1 for exactly TRIG_CYC cycles, starting the cycle after the IDLE/HOLDOFF exit.
//           Then -> WAIT_RISE, cnt=0.
//     WAIT_RISE: cnt++ each cycle.
//           Rising edge on echo_s[ch] (prev 0, now 1) -> MEASURE, cnt=1.
//           If cnt reaches ECHO_MAX_CYC first -> report timeout, go to HOLDOFF.
//           A level that is already high (stuck echo) is not an edge.
//     MEASURE: cnt++ while echo_s[ch]=1.
//           First cycle with echo_s[ch]=0 -> report width=cnt, timeout=0, go to HOLDOFF.
//           If cnt reaches ECHO_MAX_CYC with echo still high -> report width=ECHO_MAX_CYC, timeout=1.
//     HOLDOFF: wait HOLDOFF_CYC cycles, counted from the report cycle. Then:
//           ch<CH-1           -> ch++, TRIG
//           else continuous=1 -> ch=0, TRIG
//           else              -> IDLE
//   Reporting
//     meas_valid is registered and high exactly one cycle, the cycle after the reporting decision.
//     meas_ch/meas_width/meas_timeout are written with it and held until the next report.
//     Exactly one report per channel visit; no saturating wrap: cnt never exceeds ECHO_MAX_CYC.
//   Width accounting
//     A clean echo pulse of W cycles (W < ECHO_MAX_CYC) reports meas_width=W.
//     meas_valid follows the raw falling edge by 3 cycles.
//   Simultaneous events / mode changes
//     start while busy: ignored, not queued.
//     start and continuous both high in IDLE: continuous scan.
//     continuous dropped mid-scan: the current scan finishes through ch CH-1, then IDLE.
//     Echo activity on non-selected channels is ignored.
//     rst mid-pulse: trigger drops on the next clock edge.
// TESTING  (CH=2, CHW=1, CW=8, TRIG_CYC=4, ECHO_MAX_CYC=50, HOLDOFF_CYC=10)
//   1. start pulse; echo[0] high 20 cycles after trigger falls; echo[1] high 7 cycles.
//      -> trigger[0] high exactly 4 cycles.
//      -> valid {ch0, width 20, to 0}, then valid {ch1, width 7, to 0}.
//      -> busy=0 after the ch1 hold-off; trigger[1] never overlaps trigger[0].
//   2. echo[0] never rises -> valid {ch0, width 50, to 1} 50 cycles after trigger falls, then ch1 scanned.
//   3. echo[1] held high throughout -> ch1 reports timeout=1, width=50 (no edge); the FSM does not hang.
//   4. continuous=1 for 3 scans, then dropped during ch0 MEASURE -> ch1 completes, IDLE, no 4th ch0 trigger.
//   5. rst asserted during TRIG and again during MEASURE -> next cycle all outputs 0, IDLE.
//      A later start behaves as in test 1.
//   6. start pulses during busy, plus echo pulses on the idle channel -> no extra scan, results unchanged.

Source files
------------

// File: rtl/ultrasonic_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_scan_ctrl
// Brief    : Round-robin trigger / echo-timing sequencer for CH HC-SR04 rangers.
// Revision : 1.0
// ============================================================================
module ultrasonic_scan_ctrl #(
    parameter int CH           = 4,
    parameter int CHW          = 2,
    parameter int CW           = 23,
    parameter int TRIG_CYC     = 1000,
    parameter int ECHO_MAX_CYC = 3800000,
    parameter int HOLDOFF_CYC  = 6000000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           continuous,
    input  logic [CH-1:0]  echo,
    output logic [CH-1:0]  trigger,
    output logic           busy,
    output logic           meas_valid,
    output logic [CHW-1:0] meas_ch,
    output logic [CW-1:0]  meas_width,
    output logic           meas_timeout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    localparam logic [CW-1:0]  C_TRIG_LAST = CW'(TRIG_CYC - 1);
    localparam logic [CW-1:0]  C_ECHO_MAX  = CW'(ECHO_MAX_CYC);
    localparam logic [CW-1:0]  C_ECHO_LAST = CW'(ECHO_MAX_CYC - 1);
    localparam logic [CW-1:0]  C_HOLDOFF   = CW'(HOLDOFF_CYC);
    localparam logic [CHW-1:0] C_CH_LAST   = CHW'(CH - 1);

    state_t         state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CH-1:0]  echo_m_q, echo_s_q, echo_p_q;
    logic [CH-1:0]  trigger_q, trigger_d;
    logic           busy_q, busy_d;
    logic           meas_valid_q, meas_valid_d;
    logic [CHW-1:0] meas_ch_q, meas_ch_d;
    logic [CW-1:0]  meas_width_q, meas_width_d;
    logic           meas_timeout_q, meas_timeout_d;

    logic           w_echo_cur;
    logic           w_rise;
    logic           w_report;
    logic [CW-1:0]  w_rep_width;
    logic           w_rep_timeout;

    assign w_echo_cur = echo_s_q[ch_q];
    // A level already high on channel entry has no 0->1 history, so it never counts as an edge.
    assign w_rise     = w_echo_cur & ~echo_p_q[ch_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            cnt_q          <= '0;
            echo_m_q       <= '0;
            echo_s_q       <= '0;
            echo_p_q       <= '0;
            trigger_q      <= '0;
            busy_q         <= 1'b0;
            meas_valid_q   <= 1'b0;
            meas_ch_q      <= '0;
            meas_width_q   <= '0;
            meas_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            echo_m_q       <= echo;
            echo_s_q       <= echo_m_q;
            echo_p_q       <= echo_s_q;
            trigger_q      <= trigger_d;
            busy_q         <= busy_d;
            meas_valid_q   <= meas_valid_d;
            meas_ch_q      <= meas_ch_d;
            meas_width_q   <= meas_width_d;
            meas_timeout_q <= meas_timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        cnt_d          = cnt_q;
        meas_valid_d   = 1'b0;
        meas_ch_d      = meas_ch_q;
        meas_width_d   = meas_width_q;
        meas_timeout_d = meas_timeout_q;
        w_report       = 1'b0;
        w_rep_width    = cnt_q;
        w_rep_timeout  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ch_d  = '0;
                cnt_d = '0;
                if (start || continuous) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (cnt_q == C_TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_RISE: begin
                if (w_rise) begin
                    state_d = S_MEASURE;
                    cnt_d   = CW'(1);
                end else if (cnt_q == C_ECHO_LAST) begin
                    w_report      = 1'b1;
                    w_rep_width   = C_ECHO_MAX;
                    w_rep_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                if (!w_echo_cur) begin
                    w_report = 1'b1;
                end else if (cnt_q == C_ECHO_MAX) begin
                    w_report      = 1'b1;
                    w_rep_width   = C_ECHO_MAX;
                    w_rep_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLDOFF: begin
                // The report cycle is hold-off cycle 1, so exit once HOLDOFF_CYC cycles have elapsed.
                if (cnt_q >= C_HOLDOFF) begin
                    cnt_d = '0;
                    if (ch_q != C_CH_LAST) begin
                        ch_d    = ch_q + 1'b1;
                        state_d = S_TRIG;
                    end else if (continuous) begin
                        ch_d    = '0;
                        state_d = S_TRIG;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ch_d    = '0;
                cnt_d   = '0;
            end
        endcase

        if (w_report) begin
            state_d        = S_HOLDOFF;
            cnt_d          = CW'(1);
            meas_valid_d   = 1'b1;
            meas_ch_d      = ch_q;
            meas_width_d   = w_rep_width;
            meas_timeout_d = w_rep_timeout;
        end
    end

    // Trigger and busy are registered from the next state so the pins never glitch.
    always_comb begin
        trigger_d = '0;
        if (state_d == S_TRIG) begin
            trigger_d[ch_d] = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
    end

    assign trigger      = trigger_q;
    assign busy         = busy_q;
    assign meas_valid   = meas_valid_q;
    assign meas_ch      = meas_ch_q;
    assign meas_width   = meas_width_q;
    assign meas_timeout = meas_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasonic_scan_ctrl
// Brief    : Directed scoreboard bench for ultrasonic_scan_ctrl (2 channels).
// Revision : 1.0
// ============================================================================
module tb_ultrasonic_scan_ctrl;

    localparam int CH = 2, CHW = 1, CW = 8, TRIG = 4, EMAX = 50, HOLD = 10;

    logic           clk = 1'b0;
    logic           rst, start, continuous;
    logic [CH-1:0]  echo;
    logic [CH-1:0]  trigger;
    logic           busy, meas_valid, meas_timeout;
    logic [CHW-1:0] meas_ch;
    logic [CW-1:0]  meas_width;

    logic sens_e0 = 1'b0, sens_e1 = 1'b0, stuck_e, noise_e;
    int   sens_en [CH];
    int   sens_dly[CH];
    int   sens_w  [CH];
    assign echo = {sens_e1 | stuck_e | noise_e, sens_e0};

    typedef struct { int ch; int width; int to; } exp_t;
    exp_t sb[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int trig_fall_cyc[CH];
    int echo_fall_cyc[CH];
    int trig_rises[CH];
    bit overlap_seen = 1'b0;
    bit trig_chk_en;

    ultrasonic_scan_ctrl #(
        .CH(CH), .CHW(CHW), .CW(CW),
        .TRIG_CYC(TRIG), .ECHO_MAX_CYC(EMAX), .HOLDOFF_CYC(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .echo(echo),
        .trigger(trigger), .busy(busy), .meas_valid(meas_valid), .meas_ch(meas_ch),
        .meas_width(meas_width), .meas_timeout(meas_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input int w, input int t);
        exp_t e;
        e.ch = c; e.width = w; e.to = t;
        sb.push_back(e);
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            0:       return trigger[0];
            1:       return trigger[1];
            default: return busy;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic lvl, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (get_sig(which) == lvl) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait expired after %0d cycles, wanted level %0d", name, budget, lvl);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_trigger"}, int'(trigger), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_valid"}, int'(meas_valid), 0);
        check({name, "_ch"}, int'(meas_ch), 0);
        check({name, "_width"}, int'(meas_width), 0);
        check({name, "_timeout"}, int'(meas_timeout), 0);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero(name);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Sensor models: an echo pulse of sens_w cycles, sens_dly cycles after trigger falls.
    initial begin : sensor0
        forever begin
            @(negedge trigger[0]);
            if (sens_en[0] != 0) begin
                repeat (sens_dly[0]) @(posedge clk);
                #1 sens_e0 = 1'b1;
                repeat (sens_w[0]) @(posedge clk);
                #1 sens_e0 = 1'b0;
            end
        end
    end

    initial begin : sensor1
        forever begin
            @(negedge trigger[1]);
            if (sens_en[1] != 0) begin
                repeat (sens_dly[1]) @(posedge clk);
                #1 sens_e1 = 1'b1;
                repeat (sens_w[1]) @(posedge clk);
                #1 sens_e1 = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [CH-1:0] trig_prev = '0, echo_prev = '0;
        int run[CH];
        exp_t e;
        for (int g = 0; g < CH; g++) begin
            run[g] = 0; trig_rises[g] = 0; trig_fall_cyc[g] = 0; echo_fall_cyc[g] = 0;
        end
        forever begin
            @(negedge clk);
            if (trigger[0] && trigger[1]) overlap_seen = 1'b1;
            for (int g = 0; g < CH; g++) begin
                if (trigger[g]) begin
                    run[g]++;
                    if (!trig_prev[g]) trig_rises[g]++;
                end else if (trig_prev[g]) begin
                    trig_fall_cyc[g] = cyc;
                    if (trig_chk_en) check("trig_width", run[g], TRIG);
                    run[g] = 0;
                end
                if (!echo[g] && echo_prev[g]) echo_fall_cyc[g] = cyc;
            end
            trig_prev = trigger;
            echo_prev = echo;
            if (meas_valid) begin
                last_valid_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_valid_ch", int'(meas_ch), -1);
                end else begin
                    e = sb.pop_front();
                    check("meas_ch", int'(meas_ch), e.ch);
                    check("meas_width", int'(meas_width), e.width);
                    check("meas_timeout", int'(meas_timeout), e.to);
                    if (e.to != 0)
                        check("timeout_latency", cyc - trig_fall_cyc[e.ch], EMAX);
                    else
                        check("fall_latency", cyc - echo_fall_cyc[e.ch], 3);
                end
            end
        end
    end

    initial begin : stim
        int base;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; stuck_e = 1'b0; noise_e = 1'b0;
        trig_chk_en = 1'b1;
        sens_en  = '{1, 1};
        sens_dly = '{3, 5};
        sens_w   = '{20, 7};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Clean pulses on both channels, then idle exactly HOLD cycles after the last report.
        push_exp(0, 20, 0); push_exp(1, 7, 0);
        pulse_start();
        wait_sig(2, 1'b0, 1000, "t1_busy_low");
        check("t1_idle_after_holdoff", cyc - last_valid_cyc, HOLD);

        // Channel 0 never answers.
        sens_en[0] = 0;
        push_exp(0, EMAX, 1); push_exp(1, 7, 0);
        pulse_start();
        wait_sig(2, 1'b0, 1000, "t2_busy_low");
        sens_en[0] = 1;

        // Channel 1 stuck high: no edge, timeout.
        sens_en[1] = 0; stuck_e = 1'b1;
        repeat (4) @(posedge clk);
        push_exp(0, 20, 0); push_exp(1, EMAX, 1);
        pulse_start();
        wait_sig(2, 1'b0, 1000, "t3_busy_low");
        stuck_e = 1'b0; sens_en[1] = 1;
        repeat (5) @(posedge clk);

        // Continuous for three scans, dropped during the third ch0 measurement.
        base = trig_rises[0];
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 20, 0); push_exp(1, 7, 0);
        end
        @(posedge clk); #1 continuous = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_sig(0, 1'b1, 400, "t4_trig0_rise");
            wait_sig(0, 1'b0, 20, "t4_trig0_fall");
        end
        repeat (8) @(posedge clk);
        #1 continuous = 1'b0;
        wait_sig(2, 1'b0, 1000, "t4_busy_low");
        repeat (30) @(negedge clk);
        check("t4_ch0_scans", trig_rises[0] - base, 3);
        check("t4_stays_idle", int'(busy), 0);

        // Reset during TRIG and during MEASURE, then a normal scan.
        trig_chk_en = 1'b0;
        pulse_start();
        wait_sig(0, 1'b1, 10, "t5_trig_rise_a");
        repeat (2) @(negedge clk);
        do_reset("t5_rst_trig");
        repeat (40) @(posedge clk);
        pulse_start();
        wait_sig(0, 1'b1, 10, "t5_trig_rise_b");
        wait_sig(0, 1'b0, 10, "t5_trig_fall_b");
        repeat (8) @(posedge clk);
        do_reset("t5_rst_meas");
        repeat (40) @(posedge clk);
        trig_chk_en = 1'b1;
        push_exp(0, 20, 0); push_exp(1, 7, 0);
        pulse_start();
        wait_sig(2, 1'b0, 1000, "t5_busy_low");

        // Start pulses while busy and noise on the unselected channel.
        push_exp(0, 20, 0); push_exp(1, 7, 0);
        pulse_start();
        wait_sig(0, 1'b1, 10, "t6_trig0_rise");
        pulse_start();
        wait_sig(0, 1'b0, 10, "t6_trig0_fall");
        repeat (8) @(posedge clk);
        #1 noise_e = 1'b1;
        repeat (3) @(posedge clk);
        #1 noise_e = 1'b0;
        pulse_start();
        wait_sig(1, 1'b1, 200, "t6_trig1_rise");
        pulse_start();
        wait_sig(1, 1'b0, 10, "t6_trig1_fall");
        repeat (17) @(posedge clk);
        pulse_start();
        wait_sig(2, 1'b0, 1000, "t6_busy_low");
        base = trig_rises[0];
        repeat (30) @(negedge clk);
        check("t6_no_extra_scan", trig_rises[0] - base, 0);
        check("t6_stays_idle", int'(busy), 0);

        repeat (5) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        check("trigger_overlap", int'(overlap_seen), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
